// File: rtl/sign_mag_conv.sv
// Sequential sign-magnitude <-> two's-complement converter for NCH packed lanes.
// A shared datapath converts one lane per cycle under a start/busy/done handshake.
module sign_mag_conv #(
  parameter int DW  = 8,
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_mode,
  input  logic [NCH*(DW+1)-1:0]  i_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NCH*(DW+1)-1:0]  o_data,
  output logic [NCH-1:0]         o_flag
);

  localparam int LW = DW + 1;
  localparam int TW = NCH * LW;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {flag, result}; both special inputs share the {1, 0...0} pattern.
  function automatic logic [LW:0] conv_lane(input logic [LW-1:0] x, input logic mode);
    logic [DW-1:0] mag;
    logic [LW:0]   r;
    mag = x[DW-1:0];
    if (x[DW] == 1'b0) begin
      r = {1'b0, x};
    end else if (mag == {DW{1'b0}}) begin
      r = mode ? {1'b1, {LW{1'b0}}} : {1'b1, 1'b1, {DW{1'b1}}};
    end else begin
      r = {1'b0, 1'b1, (~mag) + {{(DW-1){1'b0}}, 1'b1}};
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            mode_q,  mode_d;
  logic [TW-1:0]   src_q,   src_d;
  logic [TW-1:0]   data_q,  data_d;
  logic [NCH-1:0]  flag_q,  flag_d;

  logic [LW-1:0]   lane_s;
  logic [LW:0]     res_s;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      mode_q  <= 1'b0;
      src_q   <= {TW{1'b0}};
      data_q  <= {TW{1'b0}};
      flag_q  <= {NCH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (cnt_q == LAST_LANE) begin
          state_d = DONE;
        end else begin
          state_d = CONV;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select and conversion from the latched copy of the inputs.
  always_comb begin
    lane_s = {LW{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      lane_s = (cnt_q == CW'(k)) ? src_q[k*LW +: LW] : lane_s;
    end
    res_s = conv_lane(lane_s, mode_q);
  end

  // Datapath register updates: latch on accept, write one lane per CONV cycle.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    src_d  = src_q;
    data_d = data_q;
    flag_d = flag_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          src_d  = i_data;
          mode_d = i_mode;
          data_d = {TW{1'b0}};
          flag_d = {NCH{1'b0}};
          cnt_d  = {CW{1'b0}};
        end else begin
          cnt_d  = cnt_q;
        end
      end
      CONV: begin
        cnt_d = cnt_q + CW'(1);
        for (int k = 0; k < NCH; k++) begin
          data_d[k*LW +: LW] = (cnt_q == CW'(k)) ? res_s[LW-1:0] : data_q[k*LW +: LW];
          flag_d[k]          = (cnt_q == CW'(k)) ? res_s[LW]     : flag_q[k];
        end
      end
      DONE:    cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outputs decoded from registered state and result registers.
  always_comb begin
    o_busy = (state_q != IDLE);
    o_done = (state_q == DONE);
    o_data = data_q;
    o_flag = flag_q;
  end

endmodule

// File: tb/tb_sign_mag_conv.sv
// Directed self-checking bench for sign_mag_conv (DW=8/NCH=4 and DW=2/NCH=1 builds).
module tb_sign_mag_conv;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_mode;
  logic [35:0] i_data;
  logic        o_busy;
  logic        o_done;
  logic [35:0] o_data;
  logic [3:0]  o_flag;

  logic        s_start;
  logic        s_mode;
  logic [2:0]  s_data;
  logic        s_busy;
  logic        s_done;
  logic [2:0]  s_odata;
  logic [0:0]  s_flag;

  int tests = 0;
  int fails = 0;

  sign_mag_conv #(.DW(8), .NCH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_data(i_data),
    .o_busy(o_busy), .o_done(o_done), .o_data(o_data), .o_flag(o_flag)
  );

  sign_mag_conv #(.DW(2), .NCH(1)) u_small (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_mode(s_mode), .i_data(s_data),
    .o_busy(s_busy), .o_done(s_done), .o_data(s_odata), .o_flag(s_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction on the wide DUT, collecting timing and snapshots.
  task automatic drive_txn(input logic m, input logic [35:0] d, input bit perturb,
                           output logic [35:0] res, output logic [3:0] flg,
                           output int done_cnt, output int done_at, output int busy_cnt,
                           output logic [35:0] c1_data, output logic [35:0] c2_data,
                           output logic [3:0] c2_flag);
    done_cnt = 0; done_at = 0; busy_cnt = 0;
    i_mode = m; i_data = d; i_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (c == 1) c1_data = o_data;
      if (c == 2) begin
        c2_data = o_data;
        c2_flag = o_flag;
        if (perturb) begin
          i_start = 1'b1;
          i_data  = ~d;
          i_mode  = ~m;
        end
      end
    end
    res = o_data;
    flg = o_flag;
  endtask

  task automatic run_txn(input string tag, input logic m, input logic [35:0] d,
                         input logic [35:0] exp_d, input logic [3:0] exp_f, input bit perturb);
    logic [35:0] res, c1, c2;
    logic [3:0]  flg, c2f;
    int dc, da, bc;
    drive_txn(m, d, perturb, res, flg, dc, da, bc, c1, c2, c2f);
    check({tag, "_clear"}, c1, 36'h0);
    check({tag, "_lane0"}, c2, {27'h0, exp_d[8:0]});
    check({tag, "_lane0_flag"}, c2f, {3'b000, exp_f[0]});
    check({tag, "_done_cnt"}, dc, 1);
    check({tag, "_done_at"}, da, 5);
    check({tag, "_busy_cycles"}, bc, 5);
    check({tag, "_data"}, res, exp_d);
    check({tag, "_flag"}, flg, exp_f);
  endtask

  localparam logic [35:0] T1_IN  = {9'h101, 9'h000, 9'h1FB, 9'h07F};
  localparam logic [35:0] T1_OUT = {9'h1FF, 9'h000, 9'h105, 9'h07F};
  localparam logic [35:0] T2_IN  = {9'h001, 9'h100, 9'h001, 9'h001};
  localparam logic [35:0] T2_OUT = {9'h001, 9'h1FF, 9'h001, 9'h001};
  localparam logic [35:0] T3_IN  = {9'h1FF, 9'h07F, 9'h100, 9'h105};
  localparam logic [35:0] T3_OUT = {9'h101, 9'h07F, 9'h000, 9'h1FB};
  localparam logic [35:0] RT_X   = {9'h001, 9'h180, 9'h055, 9'h1A3};
  localparam logic [35:0] RT_Y   = {9'h001, 9'h180, 9'h055, 9'h15D};

  initial begin
    logic [35:0] x, y, z, c1, c2;
    logic [3:0]  f1, f2, c2f;
    logic [8:0]  v;
    int dc, da, bc;

    rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_data = 36'h0;
    s_start = 1'b0; s_mode = 1'b0; s_data = 3'b000;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_done, 1'b0);
    check("reset_data", o_data, 36'h0);
    check("reset_flag", o_flag, 4'h0);
    check("reset_small", {s_busy, s_done, s_odata, s_flag}, 6'h0);

    run_txn("t1_mode0", 1'b0, T1_IN, T1_OUT, 4'b0000, 1'b0);
    run_txn("t2_sat", 1'b0, T2_IN, T2_OUT, 4'b0100, 1'b0);
    run_txn("t3_mode1", 1'b1, T3_IN, T3_OUT, 4'b0010, 1'b0);
    run_txn("rt_fwd", 1'b0, RT_X, RT_Y, 4'b0000, 1'b0);
    run_txn("rt_back", 1'b1, RT_Y, RT_X, 4'b0000, 1'b0);

    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 4; k++) begin
        v = 9'($urandom_range(0, 511));
        if (v == 9'h100) v = 9'h0FF;
        x[k*9 +: 9] = v;
      end
      drive_txn(1'b0, x, 1'b0, y, f1, dc, da, bc, c1, c2, c2f);
      drive_txn(1'b1, y, 1'b0, z, f2, dc, da, bc, c1, c2, c2f);
      check("rand_roundtrip", z, x);
      check("rand_flags", {f1, f2}, 8'h00);
    end

    run_txn("t4_perturb", 1'b0, T1_IN, T1_OUT, 4'b0000, 1'b1);

    // Reset after lane 1 is written discards the partial result.
    i_mode = 1'b0; i_data = T1_IN; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_lanes01", o_data[17:0], {9'h105, 9'h07F});
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_out", {o_busy, o_done, o_flag, o_data}, 42'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle", o_busy, 1'b0);
    run_txn("t5_after", 1'b0, T2_IN, T2_OUT, 4'b0100, 1'b0);

    // Small build: single lane, most-negative saturates.
    s_mode = 1'b0; s_data = 3'b100; s_start = 1'b1;
    dc = 0; da = 0; bc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_busy) bc++;
      if (s_done) begin
        dc++;
        if (da == 0) da = c;
      end
    end
    check("small_done_at", da, 2);
    check("small_busy", bc, 2);
    check("small_done_cnt", dc, 1);
    check("small_data", s_odata, 3'b111);
    check("small_flag", s_flag, 1'b1);

    // Held start re-triggers every NCH+2 cycles.
    s_data = 3'b001; s_start = 1'b1;
    dc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (s_done) dc++;
      if (c == 8) s_start = 1'b0;
    end
    check("small_retrigger", dc, 3);
    check("small_retrig_data", {s_flag, s_odata}, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
